// File: rtl/demux_1_2_6b_stream_if.sv
// Stream bundle for demux_1_2_6b_stream: one upstream beat port, two downstream channels.
// slave = the demux itself; master = the environment driving it.
interface demux_1_2_6b_stream_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] Input;
    logic             In_valid;
    logic             Select;
    logic             In_ready;
    logic [WIDTH-1:0] Output1;
    logic             Out1_valid;
    logic             Out1_ready;
    logic [WIDTH-1:0] Output2;
    logic             Out2_valid;
    logic             Out2_ready;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // a producer holding valid high keeps its payload stable until that edge.
    modport slave (
        input  Input, In_valid, Select, Out1_ready, Out2_ready,
        output In_ready, Output1, Out1_valid, Output2, Out2_valid
    );

    modport master (
        output Input, In_valid, Select, Out1_ready, Out2_ready,
        input  In_ready, Output1, Out1_valid, Output2, Out2_valid
    );
endinterface

// File: rtl/demux_1_2_6b_stream.sv
// Registered 1:2 stream demux with a DEPTH-entry FIFO per output channel.
// Optional macro DEMUX_BEAT_COUNT_EN adds saturating per-channel beat counters.
module demux_1_2_6b_stream #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic Clock,
    input  logic Reset_n,
    demux_1_2_6b_stream_if.slave bus
`ifdef DEMUX_BEAT_COUNT_EN
    ,
    input  logic       Count_clr,
    output logic [5:0] Count1,
    output logic [5:0] Count2
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [WIDTH-1:0] mem_d    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    occ_q    [2];
    logic [CW-1:0]    occ_d    [2];
    logic [WIDTH-1:0] dout_q   [2];
    logic [WIDTH-1:0] dout_d   [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_rdy;
    logic       accept;

    always_comb begin
        full = '0;
        for (int ch = 0; ch < 2; ch++) begin
            full[ch] = (occ_q[ch] == CW'(DEPTH));
        end
    end

    // Ready looks only at the selected channel's occupancy; a same-cycle pop does not free space.
    assign bus.In_ready   = ~full[bus.Select];
    assign accept         = bus.In_valid & bus.In_ready;
    assign push           = {accept & bus.Select, accept & ~bus.Select};
    assign out_rdy        = {bus.Out2_ready, bus.Out1_ready};

    assign bus.Out1_valid = (occ_q[0] != '0);
    assign bus.Out2_valid = (occ_q[1] != '0);
    assign bus.Output1    = dout_q[0];
    assign bus.Output2    = dout_q[1];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        dout_d   = dout_q;
        pop      = '0;
        for (int ch = 0; ch < 2; ch++) begin
            pop[ch] = (occ_q[ch] != '0) && out_rdy[ch];
            if (push[ch]) begin
                mem_d[ch][wr_ptr_q[ch]] = bus.Input;
                wr_ptr_d[ch]            = wr_ptr_q[ch] + PW'(1);
            end
            if (pop[ch]) begin
                rd_ptr_d[ch] = rd_ptr_q[ch] + PW'(1);
            end
            case ({push[ch], pop[ch]})
                2'b10:   occ_d[ch] = occ_q[ch] + CW'(1);
                2'b01:   occ_d[ch] = occ_q[ch] - CW'(1);
                default: occ_d[ch] = occ_q[ch];
            endcase
            // Head register: follows the next head word, holds its last value when drained.
            dout_d[ch] = (occ_d[ch] != '0) ? mem_d[ch][rd_ptr_d[ch]] : dout_q[ch];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[ch][i] <= '0;
                end
                wr_ptr_q[ch] <= '0;
                rd_ptr_q[ch] <= '0;
                occ_q[ch]    <= '0;
                dout_q[ch]   <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            dout_q   <= dout_d;
        end
    end

`ifdef DEMUX_BEAT_COUNT_EN
    logic [5:0] beat_q [2];
    logic [5:0] beat_d [2];

    // Clear takes priority over a same-edge increment.
    always_comb begin
        beat_d = beat_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (Count_clr) begin
                beat_d[ch] = '0;
            end else if (push[ch] && (beat_q[ch] != 6'd63)) begin
                beat_d[ch] = beat_q[ch] + 6'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            beat_q[0] <= '0;
            beat_q[1] <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign Count1 = beat_q[0];
    assign Count2 = beat_q[1];
`endif
endmodule

// File: doc/demux_1_2_6b_stream.md
Name: demux_1_2_6b_stream

Overview:
- Registered 1-to-2 stream demultiplexer for 6-bit data words; the inverse of the FIFO datapath's 2:1 word select.
- Routes each accepted input beat to one of two output channels, chosen by the Select value sampled with that beat.
- Each channel has a 2-entry buffer and a valid/ready handshake, so one stalled consumer does not block traffic to the other channel while its own buffer has space.
- Sits between the FIFO read port and two downstream consumers.

Parameters:
- WIDTH, 6: data word width in bits.
- DEPTH, 2: entries per output buffer; legal values are 2 and 4.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset_n  input  1  asynchronous active-low reset.
- Input  input  WIDTH  input data word.
- In_valid  input  1  Input and Select are valid this cycle.
- Select  input  1  routing for the beat: 0 sends it to Output1, 1 sends it to Output2.
- In_ready  output  1  block can accept a beat for the currently selected channel.
- Output1  output  WIDTH  head word of channel 1.
- Out1_valid  output  1  channel 1 holds at least one word.
- Out1_ready  input  1  channel 1 consumer accepts Output1.
- Output2  output  WIDTH  head word of channel 2.
- Out2_valid  output  1  channel 2 holds at least one word.
- Out2_ready  input  1  channel 2 consumer accepts Output2.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Both buffers empty; Out1_valid = Out2_valid = 0.
  - Output1 = Output2 = 0; all storage cleared.
  - Buffer state is reset immediately, independent of Clock.
  - Release is synchronous: the first accept is possible on the first rising edge with Reset_n high.
- Handshake rules:
  - In_ready = NOT full[Select]. It is combinational only from Select and buffer occupancy; it never depends on Out1_ready or Out2_ready.
  - Accept = In_valid AND In_ready, evaluated at the rising edge. On accept, Input is written to the tail of the channel chosen by Select.
  - Out<n> transfer = Out<n>_valid AND Out<n>_ready at the rising edge; pops the head entry.
  - When In_valid = 0, In_ready still reflects the currently selected channel. Upstream must hold Input and Select stable while In_valid = 1 and In_ready = 0.
- Per-channel occupancy (0..DEPTH):
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged; the head advances and the new word enters at the tail.
- Full channel with a pop in the same cycle:
  - In_ready = 0, because pop does not free space combinationally.
  - The push is refused; the upstream retries next cycle, when space is visible.
- Empty channel:
  - Out<n>_valid = 0 and Output<n> holds its last value (0 after reset).
  - Out<n>_ready is ignored; no underflow is possible.
- Latency: a word accepted at edge k is visible on Output<n> with Out<n>_valid = 1 after edge k, if its buffer was empty. There is no combinational input-to-output bypass.
- Ordering and valid stability:
  - Per-channel order is FIFO.
  - No ordering relation is defined between the two channels.
  - Out<n>_valid, once high, stays high until the transfer occurs.
  - Output<n> is stable while valid and not accepted.
- Storage and pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Full and empty are derived from a separate occupancy count, not from pointer comparison.
- Select changing while In_valid is low has no effect on state.

Optional Feature:
- Macro: DEMUX_BEAT_COUNT_EN.
- Defined: adds output ports Count1 and Count2 (6 bits each).
  - Each counts accepted input beats routed to its channel.
  - Increments on accept and saturates at 63.
  - Reset to 0 by Reset_n.
  - Adds a Count_clr input (1 bit) that synchronously zeroes both counters. Clear wins over a simultaneous increment.
- Undefined: no counters, no Count_clr or Count ports; the rest of the behaviour is identical.

Test Plan:
- Reset then idle: assert Reset_n low mid-stream with channel 1 holding 2 words → Out1_valid and Out2_valid drop to 0 immediately. After release, In_ready = 1 for both Select values.
- Single route: Input = 6'h2A, Select = 0, one-cycle In_valid, Out1_ready = 1 → Output1 = 6'h2A with Out1_valid high for exactly one cycle, following the accept edge. Out2_valid stays 0.
- Full channel: Out2_ready = 0; send 6'h01, 6'h02, 6'h03 with Select = 1 → first two accepted; In_ready = 0 on the third. Raise Out2_ready → output order 01, 02, then 03 accepted and delivered.
- Channel independence: channel 2 full and stalled; send 6'h3F with Select = 0 → accepted immediately and delivered on Output1. Channel 2 contents are unchanged.
- Simultaneous push and pop: channel 1 holds 1 word, Out1_ready = 1 and a new accept on the same edge → occupancy stays 1 and the next head is the new word. With the channel full, the refused push is confirmed by In_ready = 0.
- DEMUX_BEAT_COUNT_EN: 70 beats to channel 1, 5 to channel 2 → Count1 = 63 (saturated), Count2 = 5. Count_clr pulsed on an accepting edge → both counters read 0.
